// File: rtl/irq_chain_sink.sv
// Interrupt daisy-chain terminator: queues every non-zero chain word in a
// first-word-fall-through FIFO and presents a priority-gated request.
module irq_chain_sink #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [15:0]   irq_chain_i,
    input  logic          en_i,
    input  logic [3:0]    threshold_i,
    input  logic          ack_i,
    input  logic          ovf_clr_i,
    output logic          irq_o,
    output logic [15:0]   vect_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   cnt_o,
    output logic          ovf_o,
    output logic [7:0]    drop_cnt_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          ovf;
    logic [7:0]    drop_cnt;

    logic wr, rd, empty, full, do_wr, lost;

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);
    assign wr    = en_i && (irq_chain_i != 16'h0000);
    assign rd    = ack_i && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_wr = wr && (!full || rd);
    assign lost  = wr && full && !rd;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            drop_cnt <= 8'h00;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd)    rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, rd})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
            // Set has priority over a coincident software clear.
            if (lost)           ovf <= 1'b1;
            else if (ovf_clr_i) ovf <= 1'b0;
            if (lost && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_ptr] <= irq_chain_i;
    end

    assign vect_o     = empty ? 16'h0000 : mem[rd_ptr];
    assign irq_o      = !empty && (vect_o[15:12] > threshold_i);
    assign empty_o    = empty;
    assign full_o     = full;
    assign cnt_o      = cnt;
    assign ovf_o      = ovf;
    assign drop_cnt_o = drop_cnt;

endmodule

// File: doc/irq_chain_sink.md
# irq_chain_sink

Terminates the 16-bit interrupt daisy chain driven by the device configuration blocks' `irq_chain_o` outputs. Every non-zero chain word is one interrupt message; the sink captures each one into a FIFO and presents the oldest to the CPU/interrupt controller. The consumer sees a priority-gated request and pops messages with a one-cycle acknowledge. Overflow and drop statistics are kept for software diagnosis.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, 4..64.
- `AW`, $clog2(DEPTH): pointer width, derived; do not override.

Ports:
- `clk_i` input 1: clock, all logic on rising edge.
- `rst_i` input 1: reset, asynchronous active-high.
- `irq_chain_i` input 16: chain word from the last device in the chain; 16'h0000 = idle; any other value = one message, valid for that cycle only.
- `en_i` input 1: capture enable; when low, chain messages are discarded.
- `threshold_i` input 4: priority threshold for `irq_o`.
- `ack_i` input 1: pop the head entry.
- `ovf_clr_i` input 1: clear sticky `ovf_o`.
- `irq_o` output 1: interrupt request to the consumer.
- `vect_o` output 16: head message; 16'h0000 when empty.
- `empty_o` output 1: FIFO empty.
- `full_o` output 1: FIFO full.
- `cnt_o` output AW+1: occupancy, 0..DEPTH.
- `ovf_o` output 1: sticky, set when a message is lost to a full FIFO.
- `drop_cnt_o` output 8: saturating count of messages lost to full FIFO.

## Operation
- Message field layout: [15:12] priority, [11:0] cause/vector; the sink does not alter the word.
- Capture: `wr = en_i && irq_chain_i != 0`. The word is written at `mem[wr_ptr]` only if not full, or if full and a pop occurs in the same cycle.
- Pop: `rd = ack_i && !empty`. `ack_i` while empty is ignored and changes no state.
- Pointers: AW-bit, wrap modulo DEPTH. `cnt` is AW+1 bits: +1 on write-only, -1 on pop-only, unchanged on both or neither.
- `empty_o = (cnt==0)`, `full_o = (cnt==DEPTH)`.
- FIFO is first-word-fall-through: `vect_o = empty ? 0 : mem[rd_ptr]`, driven from registered state only.
- `irq_o = !empty && vect_o[15:12] > threshold_i`; strict compare, so priority 0 never interrupts.
- A head below threshold blocks later entries (no reordering). The consumer may still pop it with `ack_i`.
- Overflow: `wr && full && !rd` drops the word, sets `ovf_o`, and increments `drop_cnt_o`. `drop_cnt_o` saturates at 8'hFF and is cleared only by reset.
- `ovf_clr_i` clears `ovf_o`. If set and clear coincide, set wins.
- Messages discarded because `en_i` is low are not overflow: no flag, no count.
- No FSM beyond the FIFO; state is the pointers, `cnt`, `ovf`, the drop count, and `mem`.

## Timing
- Reset (asynchronous, immediate):
  - Pointers, `cnt`, `ovf_o` = 0; `drop_cnt_o` = 8'h00.
  - Resulting outputs: `empty_o` = 1, `full_o` = 0, `irq_o` = 0, `vect_o` = 16'h0000.
  - `mem` is not reset.
- Reset asserted mid-operation discards all queued messages. The first message after deassertion is accepted on the first rising edge with `rst_i` low.
- Latency, chain to output: a word present on `irq_chain_i` at edge T appears on `vect_o`/`irq_o` (if the FIFO was empty) immediately after edge T. That is 1 cycle, with no combinational path from `irq_chain_i` to any output.
- Pop: `ack_i` high at edge T advances the head after T. The next entry, or empty state, is visible in the following cycle. Consumers must not hold `ack_i` for more than one cycle per message.
- Back-to-back: one write and one pop per cycle are sustainable indefinitely at any occupancy, including full and empty.
- Write to empty + pop in the same cycle: the pop is ignored because the FIFO is empty at the edge. The written word becomes head.
- `threshold_i` changes take effect on `irq_o` combinationally in the same cycle.

## Test plan
- Reset/idle: assert `rst_i` asynchronously mid-cycle.
  - Required: `empty_o`=1, `irq_o`=0, `vect_o`=0, `cnt_o`=0 before the next edge.
  - Then hold `irq_chain_i`=0 for 20 cycles -> all outputs unchanged.
- Single message: `threshold_i`=4'h3; drive `irq_chain_i`=16'h5123 for one cycle.
  - Required: next cycle `vect_o`=16'h5123, `irq_o`=1, `cnt_o`=1.
  - Pulse `ack_i` -> `empty_o`=1, `irq_o`=0.
- Threshold gate: enqueue 16'h2044 with `threshold_i`=4'h2 -> `irq_o`=0, `empty_o`=0.
  - Lower `threshold_i` to 4'h1 -> `irq_o`=1 in the same cycle.
- Fill/overflow (DEPTH=16): 18 consecutive words 16'hA001..16'hA012.
  - Required: `full_o`=1, `cnt_o`=16, `ovf_o`=1, `drop_cnt_o`=2.
  - Popping 16 times returns 16'hA001..16'hA010 in order.
- Full with simultaneous write+pop: at `cnt_o`=16, write 16'hB000 with `ack_i`=1.
  - Required: `cnt_o` stays 16, `ovf_o` unchanged, 16'hB000 emerges last.
- `en_i`=0 discard and overflow clear:
  - With `en_i`=0, 5 chain words -> `cnt_o` unchanged, `drop_cnt_o` unchanged.
  - `ovf_clr_i` coinciding with a new overflow -> `ovf_o` stays 1; a lone `ovf_clr_i` -> `ovf_o`=0.
